// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and PC stepping constants.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD = 32'h0;
    localparam int unsigned PC_INC    = 4;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect request
// and the IF/ID handoff towards decode.
interface pc_fetch_if #(
    parameter int INS_WIDTH  = 32,
    parameter int ADDR_DEPTH = 64
);
    logic [ADDR_DEPTH-1:0] read_address;
    logic [INS_WIDTH-1:0]  instruction_in;
    logic                  redirect_valid;
    logic [ADDR_DEPTH-1:0] redirect_target;
    logic                  id_ready;
    logic                  if_valid;
    logic [INS_WIDTH-1:0]  if_instr;
    logic [ADDR_DEPTH-1:0] if_pc;
    logic                  fetch_err;
    logic                  halted;

    modport master (
        output read_address,
        output if_valid,
        output if_instr,
        output if_pc,
        output fetch_err,
        output halted,
        input  instruction_in,
        input  redirect_valid,
        input  redirect_target,
        input  id_ready
    );

    modport slave (
        input  read_address,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  fetch_err,
        input  halted,
        output instruction_in,
        output redirect_valid,
        output redirect_target,
        output id_ready
    );
endinterface

// File: rtl/pc_fetch_pc_reg.sv
// Program counter register: load has priority over increment,
// otherwise the value holds. Increment wraps naturally.
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter int                    ADDR_DEPTH = 64,
    parameter logic [ADDR_DEPTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_DEPTH-1:0] i_load_pc,
    input  logic                  i_inc,
    output logic [ADDR_DEPTH-1:0] o_pc
);
    logic [ADDR_DEPTH-1:0] r_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_DEPTH'(PC_INC);
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: BOOT/RUN/HALT control, PC stepping
// and the registered IF/ID bundle handed to decode.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int                    INS_WIDTH  = 32,
    parameter int                    ADDR_DEPTH = 64,
    parameter logic [ADDR_DEPTH-1:0] RESET_PC   = '0
) (
    input logic        clk,
    input logic        reset,
    pc_fetch_if.master bus
);
    fetch_state_t          r_state;
    logic                  r_if_valid;
    logic [INS_WIDTH-1:0]  r_if_instr;
    logic [ADDR_DEPTH-1:0] r_if_pc;
    logic                  r_fetch_err;
    logic                  r_halted;

    logic [ADDR_DEPTH-1:0] w_pc;
    logic [ADDR_DEPTH-1:0] w_load_pc;
    logic                  w_redirect;
    logic                  w_capture;
    logic                  w_halt_word;
    logic                  w_pc_inc;
    logic                  w_halt_cap;
    logic                  w_halt_idle;
    logic                  w_misaligned;

    // Redirects are only honoured once the memory preload cycle is over.
    assign w_redirect   = bus.redirect_valid && (r_state != ST_BOOT);
    assign w_capture    = (r_state == ST_RUN)
                        && (!r_if_valid || bus.id_ready)
                        && !bus.redirect_valid;
    assign w_halt_word  = bus.instruction_in
                        == INS_WIDTH'(HALT_WORD);
    assign w_pc_inc     = w_capture && !w_halt_word;
    assign w_halt_cap   = w_capture && w_halt_word;
    assign w_halt_idle  = (r_state == ST_HALT)
                        && !bus.redirect_valid;
    assign w_misaligned = is_misaligned(bus.redirect_target[1:0]);
    assign w_load_pc    = {bus.redirect_target[ADDR_DEPTH-1:2], 2'b00};

    pc_reg #(
        .ADDR_DEPTH (ADDR_DEPTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_redirect),
        .i_load_pc (w_load_pc),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_BOOT;
            r_if_valid  <= 1'b0;
            r_if_instr  <= '0;
            r_if_pc     <= '0;
            r_fetch_err <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_fetch_err <= 1'b0;
            unique case (1'b1)
                (r_state == ST_BOOT): begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
                w_redirect: begin
                    r_state     <= ST_RUN;
                    r_halted    <= 1'b0;
                    r_if_valid  <= 1'b0;
                    r_fetch_err <= w_misaligned;
                end
                w_pc_inc: begin
                    r_if_instr <= bus.instruction_in;
                    r_if_pc    <= w_pc;
                    r_if_valid <= 1'b1;
                end
                w_halt_cap: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                    if (bus.id_ready) r_if_valid <= 1'b0;
                end
                w_halt_idle: begin
                    if (bus.id_ready) r_if_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.read_address = {2'b00, w_pc[ADDR_DEPTH-1:2]};
    assign bus.if_valid     = r_if_valid;
    assign bus.if_instr     = r_if_instr;
    assign bus.if_pc        = r_if_pc;
    assign bus.fetch_err    = r_fetch_err;
    assign bus.halted       = r_halted;
endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios then
// randomized traffic against a transaction-level fetch model.
module tb_pc_fetch;
    logic clk = 1'b0;
    logic reset = 1'b0;

    pc_fetch_if #(.INS_WIDTH(32), .ADDR_DEPTH(64)) bus ();

    pc_fetch #(
        .INS_WIDTH  (32),
        .ADDR_DEPTH (64),
        .RESET_PC   (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign bus.instruction_in = mem[bus.read_address[7:0]];

    int n_chk = 0;
    int n_pass = 0;

    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_err;
    bit          m_halt;
    bit          m_boot;

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc = 64'h0;
        m_ipc = 64'h0;
        m_instr = 32'h0;
        m_valid = 0;
        m_err = 0;
        m_halt = 0;
        m_boot = 1;
    endtask

    // One clock of fetch behaviour seen as transactions.
    task automatic model_step();
        logic [31:0] w;
        logic [63:0] t;
        t = bus.redirect_target;
        if (m_boot) begin
            m_boot = 0;
            m_err = 0;
        end else if (bus.redirect_valid) begin
            m_pc = t & ~64'd3;
            m_valid = 0;
            m_err = (t % 4) != 0;
            m_halt = 0;
        end else begin
            m_err = 0;
            if (m_halt) begin
                if (bus.id_ready) m_valid = 0;
            end else if (!(m_valid && !bus.id_ready)) begin
                w = mem[(m_pc / 4) % 256];
                if (w != 0) begin
                    m_instr = w;
                    m_ipc = m_pc;
                    m_valid = 1;
                    m_pc = m_pc + 4;
                end else begin
                    m_halt = 1;
                    if (bus.id_ready) m_valid = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("read_address", bus.read_address, m_pc / 4);
        check("if_valid", 64'(bus.if_valid), 64'(m_valid));
        check("fetch_err", 64'(bus.fetch_err), 64'(m_err));
        check("halted", 64'(bus.halted), 64'(m_halt));
        if (m_valid) begin
            check("if_instr", 64'(bus.if_instr), 64'(m_instr));
            check("if_pc", bus.if_pc, m_ipc);
        end
    endtask

    task automatic cycle();
        if (reset) model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic redir(logic [63:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = t;
        cycle();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[6] = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 64'h0;
        bus.id_ready = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("rst_instr", 64'(bus.if_instr), 64'h0);
        check("rst_pc", bus.if_pc, 64'h0);

        @(negedge clk);
        reset = 1'b1;
        cycle();
        check("boot_valid", 64'(bus.if_valid), 64'h0);
        cycle();
        check("seq_pc0", bus.if_pc, 64'h0);
        check("seq_ra1", bus.read_address, 64'h1);
        cycle();
        check("seq_pc4", bus.if_pc, 64'h4);
        cycle();
        check("seq_pc8", bus.if_pc, 64'h8);

        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_pc", bus.if_pc, 64'h8);
            check("stall_ra", bus.read_address, 64'h3);
        end

        redir(64'h40);
        check("rd_flush", 64'(bus.if_valid), 64'h0);
        check("rd_ra", bus.read_address, 64'h10);
        bus.id_ready = 1'b1;
        cycle();
        check("rd_pc", bus.if_pc, 64'h40);

        redir(64'h46);
        check("mis_err", 64'(bus.fetch_err), 64'h1);
        check("mis_ra", bus.read_address, 64'h11);
        cycle();
        check("mis_err_off", 64'(bus.fetch_err), 64'h0);
        check("mis_pc", bus.if_pc, 64'h44);

        redir(64'h10);
        for (int i = 0; i < 4; i++) cycle();
        check("halt_flag", 64'(bus.halted), 64'h1);
        check("halt_valid", 64'(bus.if_valid), 64'h0);
        check("halt_ra", bus.read_address, 64'h6);
        redir(64'h0);
        check("halt_exit", 64'(bus.halted), 64'h0);
        cycle();
        check("halt_resume", bus.if_pc, 64'h0);

        redir(64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        check("wrap_pc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_ra", bus.read_address, 64'h0);

        bus.id_ready = 1'b0;
        cycle();
        reset = 1'b0;
        #1;
        model_reset();
        check("ar_valid", 64'(bus.if_valid), 64'h0);
        check("ar_ra", bus.read_address, 64'h0);
        check("ar_instr", 64'(bus.if_instr), 64'h0);
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 64'h83;
        cycle();
        check("boot_noerr", 64'(bus.fetch_err), 64'h0);
        check("boot_nord", bus.read_address, 64'h0);
        bus.redirect_valid = 1'b0;

        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
        end
        for (int n = 0; n < 3000; n++) begin
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_all();
            end
            bus.id_ready = $urandom_range(0, 3) != 0;
            bus.redirect_valid = $urandom_range(0, 9) == 0;
            bus.redirect_target = 64'($urandom_range(0, 1023));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter INS_WIDTH, 32, instruction word width.
REQ-002 Parameter ADDR_DEPTH, 64, PC and address width in bits.
REQ-003 Parameter RESET_PC, 64'h0, byte address of first fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; state clears immediately when reset==0.
REQ-006 read_address  output  ADDR_DEPTH  word index to instruction memory, = {2'b00, pc[ADDR_DEPTH-1:2]}.
REQ-007 instruction_in  input  INS_WIDTH  combinational instruction returned for read_address.
REQ-008 redirect_valid  input  1  branch/jump taken; one-cycle request.
REQ-009 redirect_target  input  ADDR_DEPTH  byte address of new PC.
REQ-010 id_ready  input  1  decode accepts if_instr this cycle.
REQ-011 if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-012 if_instr  output  INS_WIDTH  registered instruction to decode.
REQ-013 if_pc  output  ADDR_DEPTH  byte PC of if_instr.
REQ-014 fetch_err  output  1  one-cycle pulse: misaligned redirect_target received.
REQ-015 halted  output  1  high while FSM is in HALT.

Function
REQ-016 FSM states BOOT, RUN, HALT; BOOT entered on reset.
REQ-017 BOOT lasts exactly one clock after reset deasserts (instruction memory preload cycle); no capture; then RUN.
REQ-018 Internal pc register, byte address; read_address driven combinationally from pc.
REQ-019 Capture condition in RUN: (!if_valid || id_ready) && !redirect_valid.
REQ-020 On capture with instruction_in != 0: if_instr<=instruction_in, if_pc<=pc, if_valid<=1, pc<=pc+4.
REQ-021 pc+4 wraps modulo 2^ADDR_DEPTH; no error on wrap.
REQ-022 On capture with instruction_in == 0: no load, pc holds, FSM -> HALT; if_valid<=0 if id_ready, else holds.
REQ-023 Stall (if_valid && !id_ready, no redirect): pc, if_instr, if_pc, if_valid hold unchanged.
REQ-024 redirect_valid has priority over capture and stall in RUN and HALT: pc<={redirect_target[ADDR_DEPTH-1:2],2'b00}, if_valid<=0 (flush), FSM -> RUN.
REQ-025 redirect_target[1:0] != 0 -> fetch_err=1 next cycle for one cycle; redirect still taken with aligned target.
REQ-026 redirect_valid in BOOT ignored; fetch_err stays 0.
REQ-027 HALT: no capture; if_valid cleared when id_ready; exit only via redirect or reset.
REQ-028 Latency: instruction at pc appears on if_instr one cycle after capture edge; throughput one instruction/cycle with id_ready held high.
REQ-029 halted = (state == HALT), registered-state decode, no combinational input path.

Reset
REQ-030 While reset==0: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_err=0, halted=0, state=BOOT.
REQ-031 Reset mid-stall or mid-redirect discards pending instruction and redirect; no partial update survives.
REQ-032 Reset deassertion synchronous to clk is the responsibility of the top level.

Structure
REQ-033 Shared package holds fetch FSM state enum (BOOT, RUN, HALT), NOP/halt word constant 32'h0, and PC increment constant 4.
REQ-034 One sub-module, pc_reg: pc register with load/increment/hold controls; FSM and IF/ID register stay in pc_fetch.

Verification
REQ-035 Reset release, id_ready=1, memory words 0..2 nonzero -> cycle 1 BOOT, then if_pc 0,4,8 on consecutive cycles, read_address 0,1,2.
REQ-036 if_valid=1, id_ready=0 for 3 cycles -> if_instr/if_pc/pc unchanged all 3 cycles; resumes at next pc when id_ready=1.
REQ-037 Stall with if_pc=8 plus redirect_valid, target=0x40 -> next cycle if_valid=0, read_address=0x10; following cycle if_pc=0x40.
REQ-038 redirect_target=0x46 -> pc=0x44, fetch_err=1 for exactly one cycle.
REQ-039 Word at pc 0x18 is 32'h0 -> halted=1, if_valid drops after last accept, pc stays 0x18; redirect to 0x0 returns to RUN.
REQ-040 reset asserted mid-stall -> all outputs at reset values same cycle, before next clk edge.
